// File: rtl/mem_resp.sv
// mem_resp: pipelined fixed-latency 16-bit word memory for the core's memory stage.
//
// Requests are accepted on req_valid & req_ready. They travel down a shift chain
// of LATENCY-1 stage registers, and the array is accessed as a request leaves the
// last stage. A response is strobed on rsp_valid exactly LATENCY unstalled cycles
// after acceptance. Every access happens at the same depth, so ordering and
// store-to-load forwarding fall out of the structure and need no bypass.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : odd byte addresses flag rsp_err, return 0, and never write the array
//   undefined : req_addr[0] is ignored and rsp_err is tied low
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active high
//   stall      in   freezes pipeline, array and response outputs
//   req_valid  in   request present
//   req_ready  out  ~stall
//   req_wr     in   1 = store, 0 = load
//   req_addr   in   byte address; word index is req_addr[DEPTH_W:1]
//   req_wdata  in   store data
//   rsp_valid  out  response strobe
//   rsp_wr     out  echo of req_wr
//   rsp_rdata  out  load data, 0 for stores and misaligned requests
//   rsp_err    out  misaligned-access flag
module mem_resp #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 13,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic               adv;
    logic               in_err;
    logic [DEPTH_W-1:0] in_idx;

    // Signals of the request at the array-access point.
    logic               tail_valid;
    logic               tail_wr;
    logic               tail_err;
    logic [DEPTH_W-1:0] tail_idx;
    logic [15:0]        tail_wdata;

    logic [15:0] mem [0:(1 << DEPTH_W) - 1];

    // Upper address bits only alias; folding them here keeps them visibly intentional.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    assign adv       = ~stall;
    assign req_ready = ~stall;
    assign in_idx    = req_addr[DEPTH_W:1];

`ifdef MEM_ALIGN_CHECK_EN
    assign in_err = req_addr[0];
`else
    assign in_err = 1'b0;
`endif

    generate
        if (LATENCY == 1) begin : g_direct
            // No stage registers: the access happens on the acceptance edge.
            assign tail_valid = req_valid;
            assign tail_wr    = req_wr;
            assign tail_err   = in_err;
            assign tail_idx   = in_idx;
            assign tail_wdata = req_wdata;
        end else begin : g_pipe
            logic               stg_valid [NSTG];
            logic               stg_wr    [NSTG];
            logic               stg_err   [NSTG];
            logic [DEPTH_W-1:0] stg_idx   [NSTG];
            logic [15:0]        stg_wdata [NSTG];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < NSTG; i++) begin
                        stg_valid[i] <= 1'b0;
                        stg_wr[i]    <= 1'b0;
                        stg_err[i]   <= 1'b0;
                        stg_idx[i]   <= '0;
                        stg_wdata[i] <= '0;
                    end
                end else if (adv) begin
                    // req_valid low shifts in a bubble.
                    stg_valid[0] <= req_valid;
                    stg_wr[0]    <= req_wr;
                    stg_err[0]   <= in_err;
                    stg_idx[0]   <= in_idx;
                    stg_wdata[0] <= req_wdata;
                    for (int i = 1; i < NSTG; i++) begin
                        stg_valid[i] <= stg_valid[i-1];
                        stg_wr[i]    <= stg_wr[i-1];
                        stg_err[i]   <= stg_err[i-1];
                        stg_idx[i]   <= stg_idx[i-1];
                        stg_wdata[i] <= stg_wdata[i-1];
                    end
                end
            end

            assign tail_valid = stg_valid[NSTG-1];
            assign tail_wr    = stg_wr[NSTG-1];
            assign tail_err   = stg_err[NSTG-1];
            assign tail_idx   = stg_idx[NSTG-1];
            assign tail_wdata = stg_wdata[NSTG-1];
        end
    endgenerate

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (adv && tail_valid && tail_wr && !tail_err) begin
            mem[tail_idx] <= tail_wdata;
        end
    end

    // Response registers hold while stalled, so a pending strobe is seen once
    // on the first unstalled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (adv) begin
            rsp_valid <= tail_valid;
            if (tail_valid) begin
                rsp_wr    <= tail_wr;
                rsp_err   <= tail_err;
                rsp_rdata <= (tail_wr || tail_err) ? 16'h0000 : mem[tail_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed test-plan steps plus a random
// phase, all checked against a queue-based transaction model.
module tb_mem_resp;

    localparam int ADDR_W  = 16;
    localparam int DEPTH_W = 13;
    localparam int LATENCY = 4;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_wr;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;

    mem_resp #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          wr;
        int          idx;
        logic [15:0] wdata;
        bit          err;
    } req_t;

    req_t        pend[$];
    logic [15:0] mdl_mem [int];
    int          ucnt;
    int          checks;
    int          failures;
    logic        exp_valid;
    logic        exp_wr;
    logic        exp_err;
    logic [15:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_valid = 1'b0;
        exp_wr    = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 16'h0000;
    endtask

    // One clock cycle: drive, let the edge happen, update the model, compare.
    task automatic step(input bit v, input bit w, input int addr, input logic [15:0] wd, input bit st);
        req_t r;
        req_valid = v;
        req_wr    = w;
        req_addr  = addr[ADDR_W-1:0];
        req_wdata = wd;
        stall     = st;
        #1;
        check("req_ready", {31'd0, req_ready}, {31'd0, !st});
        @(posedge clk);
        if (!st) begin
            ucnt++;
            if (v) begin
                r.due   = ucnt + LATENCY - 1;
                r.wr    = w;
                r.idx   = (addr >> 1) % (1 << DEPTH_W);
                r.wdata = wd;
                r.err   = ALIGN && (addr % 2 == 1);
                pend.push_back(r);
            end
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == ucnt) begin
                r = pend.pop_front();
                exp_valid = 1'b1;
                exp_wr    = r.wr;
                exp_err   = r.err;
                if (r.err) begin
                    exp_rdata = 16'h0000;
                end else if (r.wr) begin
                    mdl_mem[r.idx] = r.wdata;
                    exp_rdata = 16'h0000;
                end else begin
                    exp_rdata = mdl_mem.exists(r.idx) ? mdl_mem[r.idx] : 16'hxxxx;
                end
            end
        end
        #1;
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("rsp_wr", {31'd0, rsp_wr}, {31'd0, exp_wr});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 16'h0000, 1'b0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ucnt      = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();

        // Power-up reset.
        #12;
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_wr", {31'd0, rsp_wr}, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
        check("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;

        // Preload words 0..63 so every later load has a defined value.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 2 * i, 16'($urandom), 1'b0);
        idle(LATENCY);

        // Store then load back-to-back.
        step(1'b1, 1'b1, 'h0010, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 'h0010, 16'h0000, 1'b0);
        idle(LATENCY);

        // Streaming loads of consecutive words.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 'h20 + 2 * i, 16'h1000 + 16'(i), 1'b0);
        idle(LATENCY);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 'h20 + 2 * i, 16'h0000, 1'b0);
        idle(LATENCY);

        // Stall while a response with 0x1234 is on the outputs.
        step(1'b1, 1'b1, 'h40, 16'h1234, 1'b0);
        idle(LATENCY);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 'h40 + 2 * i, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 'h50, 16'h0000, 1'b1);
            check("stall_hold_rdata", {16'd0, rsp_rdata}, 32'h1234);
        end
        idle(LATENCY + 1);

        // Aliasing above the index bits.
        step(1'b1, 1'b1, 'h4002, 16'hA5A5, 1'b0);
        step(1'b1, 1'b0, 'h0002, 16'h0000, 1'b0);
        idle(LATENCY);

        // Misaligned store followed by an aligned load of the same word.
        step(1'b1, 1'b1, 'h0010, 16'h0042, 1'b0);
        step(1'b1, 1'b1, 'h0011, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 'h0010, 16'h0000, 1'b0);
        idle(LATENCY);

        // Reset with three requests in flight, including a store.
        step(1'b1, 1'b1, 'h0004, 16'hDEAD, 1'b0);
        step(1'b1, 1'b0, 'h0004, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 'h0006, 16'h0000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, rsp_valid}, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        idle(LATENCY + 2);
        step(1'b1, 1'b0, 'h0004, 16'h0000, 1'b0);
        idle(LATENCY);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2 == 1,
                 int'(($urandom_range(0, 3) << 14) | $urandom_range(0, 127)),
                 16'($urandom), ($urandom % 5) == 0);
        end
        idle(LATENCY + 2);
        check("drained", pend.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Pipelined, fixed-latency word memory that services load/store requests from the processor's memory stage. Requests go in on a valid/ready handshake and come back in order on a one-cycle response strobe exactly LATENCY cycles after acceptance. It replaces the single-cycle data memory so the pipelined core can run against realistic multi-cycle memory timing.

## Interface
- ADDR_W, default 16: byte-address width of req_addr.
- DEPTH_W, default 13: the array holds 2^DEPTH_W 16-bit words, indexed by req_addr[DEPTH_W:1].
- LATENCY, default 4: cycles from request acceptance to response. Legal range is 1..8.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  freezes the whole block while high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals ~stall.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  16  store data.
- rsp_valid  out  1  response strobe, high for one unstalled cycle per request.
- rsp_wr  out  1  echo of req_wr for the response.
- rsp_rdata  out  16  load data; 0 for stores.
- rsp_err  out  1  misaligned-access flag (see Configuration).

## Operation
- **Acceptance.** A request is accepted at a rising edge where req_valid & req_ready are both high. When req_valid is low, a bubble enters the pipeline.
- **Pipeline.** The pipeline is a shift chain of LATENCY-1 stage registers. Each stage holds valid, wr, word index, wdata and err. Every unstalled edge advances the chain by one stage.
- **Array access.**
  - The access happens at the edge where a request leaves the last stage register. For LATENCY=1 that is the acceptance edge itself.
  - Store: writes wdata to mem[index] at that edge.
  - Load: registers mem[index] into rsp_rdata at that edge.
- **Ordering.**
  - Responses come back strictly in acceptance order.
  - Because every access occurs at the same pipeline depth, a load accepted after a store to the same word returns the stored value, even back-to-back.
- **Throughput.** One request per cycle, with no bubbles inserted.
- **Stall.**
  - While stall is high: no stage advances, no array access occurs, and no request is accepted.
  - rsp_* outputs hold their current values. If rsp_valid was high, it stays high, and the same response counts only once, on the first unstalled cycle after stall drops.
- **Reset.**
  - rst clears all stage valids and sets rsp_valid=0, rsp_wr=0, rsp_rdata=0, rsp_err=0.
  - Requests in flight when rst asserts are dropped with no response. Stores that had not yet reached the array have no effect.
  - Array contents are not cleared by rst and are undefined after power-up.
- **Width and addressing.**
  - Only req_addr[DEPTH_W:1] indexes the array. Address bits above DEPTH_W are ignored, so addresses alias modulo 2^(DEPTH_W+1) bytes.
  - The index and the array are both unsigned.

## Timing
- A request accepted at edge T produces rsp_valid high in the cycle after edge T+LATENCY-1, counting only unstalled edges, i.e. LATENCY cycles later.
- rsp_valid is a registered output. It drops after one cycle unless another response follows or stall holds it.
- req_ready is combinational from stall only. There is no path from req_valid to req_ready.
- rsp_rdata is only meaningful while rsp_valid=1 and rsp_wr=0. It reads 0 on store responses.

## Configuration
- Macro: MEM_ALIGN_CHECK_EN.
- **Defined:**
  - A request with req_addr[0]=1 still occupies the pipeline and returns its response at the normal time, with rsp_err=1 and rsp_rdata=0.
  - A misaligned store does not write the array.
- **Undefined:**
  - req_addr[0] is ignored.
  - rsp_err is constant 0.
  - Misaligned stores write the addressed word.

## Test plan
- **Reset.** Assert rst mid-stream while three requests are in flight. Required: rsp_valid=0 immediately (asynchronous), and no responses after rst releases.
- **Store then load, LATENCY=4.** Store 0xBEEF to addr 0x0010 at cycle 0, then load 0x0010 at cycle 1. Required: store response in cycle 4 (rsp_wr=1, rdata=0); load response in cycle 5 with rdata=0xBEEF.
- **Streaming.** Load 8 consecutive words preloaded with 0x1000..0x1007, one per cycle. Required: 8 back-to-back responses in cycles 4..11, in order, with the correct data.
- **Stall.** Assert stall for 3 cycles while rsp_valid=1 holds data 0x1234. Required:
  - req_ready=0 for those 3 cycles;
  - rsp_valid and rsp_rdata held throughout;
  - exactly one response is counted;
  - remaining responses are delayed by 3 cycles.
- **Aliasing.** With DEPTH_W=13, store 0xA5A5 to 0x4002, then load 0x0002. Required: rdata=0xA5A5.
- **Alignment check, MEM_ALIGN_CHECK_EN defined.** Store 0xFFFF to 0x0011, then load 0x0010 (preloaded with 0x0042). Required:
  - the store response has rsp_err=1;
  - the load returns 0x0042 with rsp_err=0.
  - With the macro undefined, the same sequence returns 0xFFFF and rsp_err=0.
